// File: rtl/alu_div.sv
// Multi-cycle 2N/N restoring divider: quotient on y, remainder on outToA, with ALU-style flags.
// Optional signed support is built when ALU_DIV_SIGNED_EN is defined (adds the isSigned port).
module alu_div #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividendHi,
    input  logic [N-1:0] dividendLo,
    input  logic [N-1:0] divisor,
`ifdef ALU_DIV_SIGNED_EN
    input  logic         isSigned,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic [N-1:0] outToA,
    output logic         zero,
    output logic         negative,
    output logic         overflow,
    output logic         divByZero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST  = CW'(N-1);
    localparam logic [CW-1:0] CNT_STEP  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [N-1:0]  ALL_ONES  = {N{1'b1}};
    localparam logic [N-1:0]  ALL_ZEROS = {N{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;

    logic [2*N-1:0] dvd_mag_s;
    logic [N-1:0]   dvs_mag_s;
    logic           dvz_s;
    logic           early_ovf_s;

    logic [N-1:0]   rem_r;
    logic [N-1:0]   quo_r;
    logic [N-1:0]   dvs_r;
    logic [CW-1:0]  cnt_r;

    logic [N:0]     shift_s;
    logic [N-1:0]   trial_s;
    logic           ge_s;
    logic [N-1:0]   rem_next_s;

    logic [N-1:0]   fix_y_s;
    logic [N-1:0]   fix_a_s;
    logic           fix_ovf_s;

    logic [N-1:0]   res_y_r;
    logic [N-1:0]   res_a_r;
    logic           res_ovf_r;
    logic           res_dbz_r;

    logic           busy_r;
    logic           done_r;
    logic [N-1:0]   y_r;
    logic [N-1:0]   a_r;
    logic           zero_r;
    logic           negative_r;
    logic           overflow_r;
    logic           dbz_r;

`ifdef ALU_DIV_SIGNED_EN
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_MAG = {1'b1, {(N-1){1'b0}}};

    logic           q_neg_s;
    logic           r_neg_s;
    logic           sgn_r;
    logic           q_neg_r;
    logic           r_neg_r;
    logic [N-1:0]   q_fix_s;
    logic [N-1:0]   r_fix_s;
    logic           range_ovf_s;

    // Operand magnitudes and result signs for two's-complement requests.
    always_comb begin
        dvd_mag_s = {dividendHi, dividendLo};
        dvs_mag_s = divisor;
        q_neg_s   = 1'b0;
        r_neg_s   = 1'b0;
        if (isSigned) begin
            dvd_mag_s = dividendHi[N-1] ? -{dividendHi, dividendLo} : {dividendHi, dividendLo};
            dvs_mag_s = divisor[N-1] ? -divisor : divisor;
            q_neg_s   = dividendHi[N-1] ^ divisor[N-1];
            r_neg_s   = dividendHi[N-1];
        end else begin
            dvd_mag_s = {dividendHi, dividendLo};
            dvs_mag_s = divisor;
        end
    end

    // Sign restoration and signed range check on the finished magnitudes.
    always_comb begin
        q_fix_s = q_neg_r ? -quo_r : quo_r;
        r_fix_s = r_neg_r ? -rem_r : rem_r;
        if (q_neg_r) begin
            range_ovf_s = (quo_r > MIN_MAG);
        end else begin
            range_ovf_s = (quo_r > MAX_POS);
        end
        if (sgn_r && range_ovf_s) begin
            fix_y_s   = ALL_ONES;
            fix_a_s   = ALL_ZEROS;
            fix_ovf_s = 1'b1;
        end else begin
            fix_y_s   = q_fix_s;
            fix_a_s   = r_fix_s;
            fix_ovf_s = 1'b0;
        end
    end

    // Sign context captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_r   <= 1'b0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            sgn_r   <= isSigned;
            q_neg_r <= q_neg_s;
            r_neg_r <= r_neg_s;
        end
    end
`else
    assign dvd_mag_s = {dividendHi, dividendLo};
    assign dvs_mag_s = divisor;
    assign fix_y_s   = quo_r;
    assign fix_a_s   = rem_r;
    assign fix_ovf_s = 1'b0;
`endif

    // A quotient that cannot fit N bits shows up as high word >= divisor.
    assign dvz_s       = (divisor == ALL_ZEROS);
    assign early_ovf_s = (dvd_mag_s[2*N-1:N] >= dvs_mag_s);

    // One restoring shift-subtract step on the partial remainder.
    always_comb begin
        shift_s = {rem_r, quo_r[N-1]};
        ge_s    = (shift_s >= {1'b0, dvs_r});
        trial_s = shift_s[N-1:0] - dvs_r;
        if (ge_s) begin
            rem_next_s = trial_s;
        end else begin
            rem_next_s = shift_s[N-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (dvz_s || early_ovf_s) ? DONE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, iteration and result staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r     <= ALL_ZEROS;
            quo_r     <= ALL_ZEROS;
            dvs_r     <= ALL_ZEROS;
            cnt_r     <= CNT_ZERO;
            res_y_r   <= ALL_ZEROS;
            res_a_r   <= ALL_ZEROS;
            res_ovf_r <= 1'b0;
            res_dbz_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rem_r     <= dvd_mag_s[2*N-1:N];
                        quo_r     <= dvd_mag_s[N-1:0];
                        dvs_r     <= dvs_mag_s;
                        cnt_r     <= CNT_ZERO;
                        // Early-exit results; a normal run overwrites these in FIX.
                        res_y_r   <= ALL_ONES;
                        res_a_r   <= ALL_ZEROS;
                        res_ovf_r <= dvz_s | early_ovf_s;
                        res_dbz_r <= dvz_s;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[N-2:0], ge_s};
                    cnt_r <= cnt_r + CNT_STEP;
                end
                FIX: begin
                    res_y_r   <= fix_y_s;
                    res_a_r   <= fix_a_s;
                    res_ovf_r <= fix_ovf_s;
                    res_dbz_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and visible result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            y_r        <= ALL_ZEROS;
            a_r        <= ALL_ZEROS;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
            overflow_r <= 1'b0;
            dbz_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= start;
                    done_r <= 1'b0;
                end
                DONE: begin
                    done_r     <= 1'b1;
                    y_r        <= res_y_r;
                    a_r        <= res_a_r;
                    zero_r     <= (res_y_r == ALL_ZEROS) && (res_a_r == ALL_ZEROS);
                    negative_r <= res_y_r[N-1];
                    overflow_r <= res_ovf_r;
                    dbz_r      <= res_dbz_r;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign y         = y_r;
    assign outToA    = a_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
    assign overflow  = overflow_r;
    assign divByZero = dbz_r;

endmodule

// File: tb/tb_alu_div.sv
// Scoreboard bench for alu_div: an arithmetic model predicts each result and latency at accept time.
`timescale 1ns/1ps
module tb_alu_div;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividendHi;
    logic [N-1:0] dividendLo;
    logic [N-1:0] divisor;
`ifdef ALU_DIV_SIGNED_EN
    logic         isSigned;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] y;
    logic [N-1:0] outToA;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         divByZero;

    alu_div #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividendHi (dividendHi),
        .dividendLo (dividendLo),
        .divisor    (divisor),
`ifdef ALU_DIV_SIGNED_EN
        .isSigned   (isSigned),
`endif
        .busy       (busy),
        .done       (done),
        .y          (y),
        .outToA     (outToA),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow),
        .divByZero  (divByZero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] y;
        logic [15:0] a;
        logic        z;
        logic        n;
        logic        o;
        logic        d;
        int          lat;
        int          k;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] hi, input logic [15:0] lo,
                                   input logic [15:0] dv, input logic sg);
        exp_t   r;
        longint dvd, dvs, q, rm, adv, ads;
        r.lat = 18;
        r.k   = 0;
        if (sg) begin
            dvd = longint'($signed({hi, lo}));
            dvs = longint'($signed(dv));
        end else begin
            dvd = longint'({hi, lo});
            dvs = longint'(dv);
        end
        if (dvs == 0) begin
            r.y = 16'hFFFF; r.a = 16'h0000; r.o = 1'b1; r.d = 1'b1; r.lat = 1;
        end else begin
            q   = dvd / dvs;
            rm  = dvd % dvs;
            adv = (dvd < 0) ? -dvd : dvd;
            ads = (dvs < 0) ? -dvs : dvs;
            if ((adv >> 16) >= ads) r.lat = 1;
            r.d = 1'b0;
            if (sg ? (q > 32767 || q < -32768) : (q > 65535)) begin
                r.y = 16'hFFFF; r.a = 16'h0000; r.o = 1'b1;
            end else begin
                r.y = q[15:0]; r.a = rm[15:0]; r.o = 1'b0;
            end
        end
        r.z = (r.y == 16'h0000) && (r.a == 16'h0000);
        r.n = r.y[15];
        return r;
    endfunction

    // Result monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt = done_cnt + 1;
            chk("busy_at_done", 32'(busy), 32'd1);
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("y",         32'(y),         32'(mon_e.y));
                chk("outToA",    32'(outToA),    32'(mon_e.a));
                chk("zero",      32'(zero),      32'(mon_e.z));
                chk("negative",  32'(negative),  32'(mon_e.n));
                chk("overflow",  32'(overflow),  32'(mon_e.o));
                chk("divByZero", 32'(divByZero), 32'(mon_e.d));
                chk("latency",   32'(cyc - mon_e.k), 32'(mon_e.lat));
            end
        end
    end

    task automatic start_op(input logic [15:0] hi, input logic [15:0] lo,
                            input logic [15:0] dv, input logic sg, input bit track);
        exp_t e;
        e = model(hi, lo, dv, sg);
        @(negedge clk);
        dividendHi = hi;
        dividendLo = lo;
        divisor    = dv;
`ifdef ALU_DIV_SIGNED_EN
        isSigned   = sg;
`endif
        start      = 1'b1;
        @(posedge clk);
        #1;
        e.k = cyc;
        if (track) sb_q.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        dividendHi = 16'($urandom);
        dividendLo = 16'($urandom);
        divisor    = 16'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_count", 32'(done_cnt - prev), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] hi, input logic [15:0] lo,
                         input logic [15:0] dv, input logic sg);
        int p;
        p = done_cnt;
        start_op(hi, lo, dv, sg, 1'b1);
        wait_done(p);
        @(negedge clk);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_y"},         32'(y),         32'd0);
        chk({tag, "_outToA"},    32'(outToA),    32'd0);
        chk({tag, "_zero"},      32'(zero),      32'd0);
        chk({tag, "_negative"},  32'(negative),  32'd0);
        chk({tag, "_overflow"},  32'(overflow),  32'd0);
        chk({tag, "_divByZero"}, 32'(divByZero), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        logic [15:0] rdv, rhi, rlo;
        rst        = 1'b1;
        start      = 1'b0;
        dividendHi = 16'h0000;
        dividendLo = 16'h0000;
        divisor    = 16'h0000;
`ifdef ALU_DIV_SIGNED_EN
        isSigned   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        do_op(16'h0001, 16'h0000, 16'h0003, 1'b0);
        do_op(16'h1234, 16'h5678, 16'h0000, 1'b0);
        do_op(16'h0003, 16'h1234, 16'h0003, 1'b0);
        do_op(16'h0000, 16'h0000, 16'h0005, 1'b0);
        do_op(16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b0);
        do_op(16'h0001, 16'h0000, 16'h0001, 1'b0);
        do_op(16'h0000, 16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rdv = 16'($urandom_range(1, 65535));
            rhi = 16'($urandom_range(0, int'(rdv) - 1));
            rlo = 16'($urandom);
            do_op(rhi, rlo, rdv, 1'b0);
        end

        // A second start while running must be ignored.
        p = done_cnt;
        start_op(16'h0001, 16'h0000, 16'h0003, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        dividendHi = 16'h0000;
        dividendLo = 16'h0009;
        divisor    = 16'h0002;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done(p);
        p = done_cnt;
        repeat (25) @(negedge clk);
        chk("no_extra_done", 32'(done_cnt - p), 32'd0);

        // Reset in the middle of a run aborts it without a done pulse.
        p = done_cnt;
        start_op(16'h0002, 16'h0000, 16'h0007, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt - p), 32'd0);
        do_op(16'h0000, 16'h0064, 16'h0007, 1'b0);

`ifdef ALU_DIV_SIGNED_EN
        do_op(16'hFFFF, 16'hFFF9, 16'h0002, 1'b1);
        do_op(16'hFFFF, 16'h8000, 16'h0001, 1'b1);
        do_op(16'h0000, 16'h8000, 16'h0001, 1'b1);
        do_op(16'h0000, 16'h0007, 16'hFFFE, 1'b1);
        do_op(16'hFFFF, 16'h0000, 16'hFFFF, 1'b1);
        do_op(16'hFFFF, 16'hFFF9, 16'h0000, 1'b1);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
